// File: rtl/mac1_pkg.sv
// Shared constants and the saturating accumulate helper for the mac1 datapath.
package mac1_pkg;
    localparam int LANES = 3;
    localparam int DW    = 8;
    localparam int ACCW  = 20;
    localparam int PW    = 2 * DW;
    localparam int SW    = PW + $clog2(LANES);

    localparam logic [ACCW-1:0] ACC_MAX = {ACCW{1'b1}};

    // One extra bit catches overflow; acc + s can never exceed 2^(ACCW+1)-1.
    function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] a,
                                                input logic [SW-1:0]   s);
        logic [ACCW:0] t;
        t = {1'b0, a} + (ACCW + 1)'(s);
        return t[ACCW] ? ACC_MAX : t[ACCW-1:0];
    endfunction
endpackage

// File: rtl/mac1_lane.sv
// One unsigned DW x DW multiplier lane with a registered full-precision product.
module mac1_lane
    import mac1_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] attr,
    input  logic [DW-1:0] coeff,
    output logic [PW-1:0] prod
);
    logic [PW-1:0] prod_d, prod_q;

    always_comb begin
        prod_d = PW'(attr) * PW'(coeff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) prod_q <= '0;
        else     prod_q <= prod_d;
    end

    assign prod = prod_q;
endmodule

// File: rtl/mac1_core.sv
// Three-lane unsigned MAC: registered lane products, adder tree, saturating accumulator.
module mac1_core
    import mac1_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES*DW-1:0]   inputattr,
    input  logic [LANES*DW-1:0]   inputcoeff,
    output logic [ACCW-1:0]       acc
);
    logic [LANES-1:0][DW-1:0] attr_v, coeff_v;
    logic [LANES-1:0][PW-1:0] prod;
    logic [SW-1:0]            sum;
    logic [ACCW-1:0]          acc_d, acc_q;

    assign attr_v  = inputattr;
    assign coeff_v = inputcoeff;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac1_lane u_lane (
            .clk   (clk),
            .rst   (rst),
            .attr  (attr_v[i]),
            .coeff (coeff_v[i]),
            .prod  (prod[i])
        );
    end

    always_comb begin
        sum = '0;
        for (int i = 0; i < LANES; i++) sum = sum + SW'(prod[i]);
    end

    // Saturation is sticky for free: ACC_MAX + anything re-saturates.
    always_comb begin
        acc_d = sat_add(acc_q, sum);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) acc_q <= '0;
        else     acc_q <= acc_d;
    end

    assign acc = acc_q;
endmodule

// File: tb/tb_mac1_core.sv
// Randomized self-checking bench for mac1_core against a dot-product/saturation model.
module tb_mac1_core;
    localparam int  LANES   = 3;
    localparam int  DW      = 8;
    localparam int  ACCW    = 20;
    localparam longint MAXV = (64'd1 << ACCW) - 1;

    logic                 clk;
    logic                 rst;
    logic [LANES*DW-1:0]  attr, coeff;
    logic [ACCW-1:0]      acc;

    int checks = 0;
    int errors = 0;

    longint acc_m;    // model accumulator
    longint stage_m;  // model dot product captured by the last edge

    mac1_core dut (
        .clk        (clk),
        .rst        (rst),
        .inputattr  (attr),
        .inputcoeff (coeff),
        .acc        (acc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint dot(input logic [LANES*DW-1:0] a,
                                   input logic [LANES*DW-1:0] c);
        longint s = 0;
        for (int i = 0; i < LANES; i++)
            s += longint'(a[i*DW +: DW]) * longint'(c[i*DW +: DW]);
        return s;
    endfunction

    task automatic step(input string tag);
        @(posedge clk);
        if (!rst) begin
            acc_m   = (acc_m + stage_m > MAXV) ? MAXV : acc_m + stage_m;
            stage_m = dot(attr, coeff);
        end
        #1;
        chk(tag, longint'(acc), acc_m);
    endtask

    task automatic drive(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] c);
        attr  = a;
        coeff = c;
    endtask

    // Assert mid-cycle, check the clear lands before any edge, release on negedge.
    task automatic do_reset();
        #2 rst = 1'b1;
        acc_m   = 0;
        stage_m = 0;
        #1 chk("rst_async", longint'(acc), 0);
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        acc_m = 0;
        stage_m = 0;
        drive({8'd9, 8'd8, 8'd7}, {8'd3, 8'd4, 8'd5});
        rst = 1'b1;
        #3 chk("rst_initial", longint'(acc), 0);
        @(posedge clk); #1 chk("rst_held_edge", longint'(acc), 0);
        @(negedge clk) rst = 1'b0;
        step("rst_release");
        chk("rst_release_zero", longint'(acc), 0);

        // Flush the word captured on release, then zero inputs.
        drive('0, '0);
        do_reset();
        for (int i = 0; i < 5; i++) step("zero_in");
        chk("zero_final", longint'(acc), 0);

        drive({8'd49, 8'd30, 8'd14}, {8'd10, 8'd0, 8'd0});
        step("w1");
        drive({8'd47, 8'd32, 8'd13}, {8'd10, 8'd0, 8'd0});
        step("w2");
        chk("two_word_490", longint'(acc), 490);
        drive('0, '0);
        step("w3");
        chk("two_word_960", longint'(acc), 960);
        step("w4");
        chk("two_word_hold", longint'(acc), 960);

        // Nonzero word sits in stage 1 when reset hits; it must be discarded.
        drive({8'd200, 8'd100, 8'd50}, {8'd3, 8'd2, 8'd1});
        step("inflight_load");
        chk("inflight_960", longint'(acc), 960);
        drive('0, '0);
        do_reset();
        step("post_rst1");
        step("post_rst2");
        chk("inflight_discarded", longint'(acc), 0);

        for (int l = 0; l < LANES; l++) begin
            logic [LANES*DW-1:0] a, c;
            a = '0; c = '0;
            a[l*DW +: DW] = 8'd3;
            c[l*DW +: DW] = 8'd7;
            drive(a, c);
            step("lane_load");
            drive('0, '0);
            step("lane_acc");
            chk($sformatf("lane%0d_plus21", l), longint'(acc), 21 * (l + 1));
        end

        do_reset();
        drive({LANES*DW{1'b1}}, {LANES*DW{1'b1}});
        step("sat_fill");
        for (int k = 1; k <= 5; k++) begin
            step("sat_step");
            chk($sformatf("sat_step%0d", k), longint'(acc), 195075 * k);
        end
        step("sat_clip");
        chk("sat_clip", longint'(acc), 1048575);
        for (int k = 0; k < 3; k++) begin
            step("sat_hold");
            chk("sat_sticky", longint'(acc), 1048575);
        end

        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [LANES*DW-1:0] a, c;
            a = LANES*DW'($urandom);
            c = LANES*DW'($urandom);
            case ($urandom_range(3))
                0: begin a &= 24'h0F0F0F; c &= 24'h0F0F0F; end
                1: c = '0;
                default: ;
            endcase
            drive(a, c);
            if ($urandom_range(24) == 0) do_reset();
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
